ahbl_master_arbiter: RTL

//  2-master AHB-Lite arbiter/multiplexer: the master-side counterpart of the slave splitter.
//  M0 (CPU) and M1 (DMA) share one AHB-Lite bus that feeds the splitter.
//  AHB-Lite masters have no bus-request or grant signals. A transfer from a non-granted master
//  is therefore captured into a per-master pending register. That master is then stalled

---
 rtl/ahbl_master_arbiter_if.sv | 21 ++
 rtl/ahbl_master_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/ahbl_master_arbiter_if.sv
// AHB-Lite signal bundle shared by the master-side ports and the downstream bus.
// The arbiter takes the slave view on each master port and the master view on the shared bus.
interface ahbl_master_arbiter_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY
  );
endinterface

// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter: a non-owner transfer is parked in a pending register and
// the master is stalled through its own HREADY until the transfer is replayed on the bus.
module ahbl_master_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  ahbl_master_arbiter_if.slave         m0,
  ahbl_master_arbiter_if.slave         m1,
  ahbl_master_arbiter_if.master        bus
);
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
  } xfer_t;

  xfer_t      live   [2];
  xfer_t      pend_q [2];
  xfer_t      addr_x;
  logic [1:0] pend_v_q;
  logic       grant_q, grant_d;
  logic       rr_last_q, rr_last_d;
  logic       dph_v_q, dph_own_q;
  logic [1:0] req, rdy, capture, rel;
  logic       lock;

  assign live[0] = '{addr: m0.HADDR, trans: m0.HTRANS, write: m0.HWRITE, size: m0.HSIZE};
  assign live[1] = '{addr: m1.HADDR, trans: m1.HTRANS, write: m1.HWRITE, size: m1.HSIZE};

  // A replayed transfer takes precedence over whatever the owner is driving live.
  assign addr_x = pend_v_q[grant_q] ? pend_q[grant_q] : live[grant_q];

  assign bus.HADDR  = addr_x.addr;
  assign bus.HTRANS = addr_x.trans;
  assign bus.HWRITE = addr_x.write;
  assign bus.HSIZE  = addr_x.size;
  assign bus.HWDATA = dph_own_q ? m1.HWDATA : m0.HWDATA;

  assign m0.HRDATA = bus.HRDATA;
  assign m1.HRDATA = bus.HRDATA;
  assign m0.HREADY = rdy[0];
  assign m1.HREADY = rdy[1];

  always_comb begin
    req     = '0;
    rdy     = '0;
    capture = '0;
    rel     = '0;
    for (int i = 0; i < 2; i++) begin
      req[i]     = pend_v_q[i] | live[i].trans[1];
      rdy[i]     = (dph_v_q && (dph_own_q == 1'(i))) ? bus.HREADY : !pend_v_q[i];
      rel[i]     = (grant_q == 1'(i)) && bus.HREADY;
      // The owner's live transfer goes straight onto an accepting bus; anything else is parked.
      capture[i] = rdy[i] && live[i].trans[1] &&
                   !((grant_q == 1'(i)) && !pend_v_q[i] && bus.HREADY);
    end
  end

  always_comb begin
    lock      = (addr_x.trans == HTRANS_SEQ) ||
                (live[grant_q].trans == HTRANS_SEQ) ||
                (live[grant_q].trans == HTRANS_BUSY);
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    if (bus.HREADY && !lock) begin
      if (FIXED_PRIO) begin
        if (req[0])      grant_d = 1'b0;
        else if (req[1]) grant_d = 1'b1;
      end else if (req[~grant_q]) begin
        grant_d = ~grant_q;
      end
      rr_last_d = grant_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
      pend_v_q  <= 2'b00;
      dph_v_q   <= 1'b0;
      dph_own_q <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      for (int i = 0; i < 2; i++) begin
        if (capture[i])  pend_v_q[i] <= 1'b1;
        else if (rel[i]) pend_v_q[i] <= 1'b0;
      end
      if (bus.HREADY) begin
        dph_v_q   <= addr_x.trans[1];
        dph_own_q <= grant_q;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    for (int i = 0; i < 2; i++) begin
      if (capture[i]) pend_q[i] <= live[i];
    end
  end
endmodule
